// File: rtl/fir_coef_pair_loader.sv
// Stability-qualified, frame-aligned loader for the FIR b18/b19 coefficient pair.
// Optional macro FIR_COEF_SYM_CLAMP_EN: clamp 16'h8000 halves to 16'h8001 at the shadow load.
module fir_coef_pair_loader #(
    parameter int          STABLE_CYCLES = 4,
    parameter logic [31:0] RESET_WORD    = 32'h0000_0000,
    parameter int          CNT_W         = 8
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic [31:0]      user_data_in,
    input  logic             frame_sync,
    input  logic             load_en,
    output logic [15:0]      coef_b18,
    output logic [15:0]      coef_b19,
    output logic             coef_update,
    output logic             update_pending,
    output logic [CNT_W-1:0] update_count
);

    localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t         state;
    logic [31:0]    last_seen;
    logic [31:0]    candidate;
    logic [31:0]    shadow;
    logic [CW-1:0]  counter;

    function automatic logic [31:0] clamp_word(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef FIR_COEF_SYM_CLAMP_EN
        if (w[31:16] == 16'h8000) r[31:16] = 16'h8001;
        if (w[15:0] == 16'h8000)  r[15:0]  = 16'h8001;
`endif
        return r;
    endfunction

    // candidate always holds the raw (unclamped) word, so comparisons and
    // last_seen never see the clamped value and cannot retrigger on it.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state          <= IDLE;
            last_seen      <= RESET_WORD;
            candidate      <= RESET_WORD;
            shadow         <= RESET_WORD;
            counter        <= '0;
            coef_b18       <= RESET_WORD[31:16];
            coef_b19       <= RESET_WORD[15:0];
            coef_update    <= 1'b0;
            update_pending <= 1'b0;
            update_count   <= '0;
        end else begin
            coef_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (user_data_in != last_seen) begin
                        candidate <= user_data_in;
                        if (STABLE_CYCLES <= 1) begin
                            shadow         <= clamp_word(user_data_in);
                            update_pending <= 1'b1;
                            state          <= PENDING;
                        end else begin
                            counter <= CW'(1);
                            state   <= SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    if (user_data_in != candidate) begin
                        // Falling back to the active word abandons the update entirely.
                        candidate <= user_data_in;
                        if (user_data_in == last_seen) begin
                            counter <= '0;
                            state   <= IDLE;
                        end else begin
                            counter <= CW'(1);
                        end
                    end else if (counter == CW'(STABLE_CYCLES - 1)) begin
                        shadow         <= clamp_word(candidate);
                        update_pending <= 1'b1;
                        state          <= PENDING;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end

                PENDING: begin
                    if (frame_sync && load_en) begin
                        coef_b18       <= shadow[31:16];
                        coef_b19       <= shadow[15:0];
                        last_seen      <= candidate;
                        update_count   <= update_count + CNT_W'(1);
                        update_pending <= 1'b0;
                        coef_update    <= 1'b1;
                        counter        <= '0;
                        state          <= IDLE;
                    end else if (user_data_in != candidate) begin
                        candidate <= user_data_in;
                        if (user_data_in == last_seen) begin
                            update_pending <= 1'b0;
                            counter        <= '0;
                            state          <= IDLE;
                        end else if (STABLE_CYCLES <= 1) begin
                            shadow <= clamp_word(user_data_in);
                        end else begin
                            update_pending <= 1'b0;
                            counter        <= CW'(1);
                            state          <= SETTLE;
                        end
                    end
                end

                default: begin
                    update_pending <= 1'b0;
                    counter        <= '0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_pair_loader.sv
// Directed bench for fir_coef_pair_loader; expected commits queued in a scoreboard.
// Honours FIR_COEF_SYM_CLAMP_EN for the 16'h8000 clamp expectation.
module tb_fir_coef_pair_loader;

    logic        user_clk;
    logic        user_rst_n;
    logic [31:0] user_data_in;
    logic        frame_sync;
    logic        load_en;
    logic [15:0] coef_b18;
    logic [15:0] coef_b19;
    logic        coef_update;
    logic        update_pending;
    logic [7:0]  update_count;

    int          n_checks;
    int          n_passed;
    int          n_failed;
    logic [31:0] exp_q[$];
    logic [31:0] exp_clamp;

    fir_coef_pair_loader #(
        .STABLE_CYCLES(4),
        .RESET_WORD(32'h0000_0000),
        .CNT_W(8)
    ) dut (
        .user_clk(user_clk),
        .user_rst_n(user_rst_n),
        .user_data_in(user_data_in),
        .frame_sync(frame_sync),
        .load_en(load_en),
        .coef_b18(coef_b18),
        .coef_b19(coef_b19),
        .coef_update(coef_update),
        .update_pending(update_pending),
        .update_count(update_count)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_passed++;
        end else begin
            n_failed++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // One call = one rising edge with these inputs; returns just after that edge.
    task automatic applyStimulus(input logic [31:0] word, input logic fs, input logic le);
        @(negedge user_clk);
        user_data_in = word;
        frame_sync   = fs;
        load_en      = le;
        @(posedge user_clk);
        #1;
    endtask

    // Every coef_update pulse must match the oldest expected commit.
    always @(negedge user_clk) begin
        if (user_rst_n && coef_update) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_commit", 32'd1, 32'd0);
            end else begin
                checkOutput("scoreboard_taps", {coef_b18, coef_b19}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_passed = 0;
        n_failed = 0;
`ifdef FIR_COEF_SYM_CLAMP_EN
        exp_clamp = 32'h8001_8001;
`else
        exp_clamp = 32'h8000_8000;
`endif
        user_rst_n   = 1'b0;
        user_data_in = 32'h0;
        frame_sync   = 1'b0;
        load_en      = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        checkOutput("rst_taps", {coef_b18, coef_b19}, 32'h0);
        checkOutput("rst_count", 32'(update_count), 32'd0);
        checkOutput("rst_pending", 32'(update_pending), 32'd0);
        checkOutput("rst_update", 32'(coef_update), 32'd0);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        applyStimulus(32'h0, 1'b1, 1'b1);
        checkOutput("idle_no_update", 32'(coef_update), 32'd0);
        checkOutput("idle_count", 32'(update_count), 32'd0);

        // Basic qualify and commit
        repeat (3) applyStimulus(32'h0012_FFF0, 1'b0, 1'b1);
        checkOutput("basic_pending_early", 32'(update_pending), 32'd0);
        applyStimulus(32'h0012_FFF0, 1'b0, 1'b1);
        checkOutput("basic_pending_4th", 32'(update_pending), 32'd1);
        checkOutput("basic_taps_before", {coef_b18, coef_b19}, 32'h0);
        exp_q.push_back(32'h0012_FFF0);
        applyStimulus(32'h0012_FFF0, 1'b1, 1'b1);
        checkOutput("basic_taps", {coef_b18, coef_b19}, 32'h0012_FFF0);
        checkOutput("basic_update", 32'(coef_update), 32'd1);
        checkOutput("basic_count", 32'(update_count), 32'd1);
        checkOutput("basic_pending_clr", 32'(update_pending), 32'd0);
        applyStimulus(32'h0012_FFF0, 1'b0, 1'b1);
        checkOutput("basic_update_one", 32'(coef_update), 32'd0);

        // Skewed word restarts qualification
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h1111_0000, 1'b1, 1'b1);
            applyStimulus(32'h1111_0000, 1'b0, 1'b1);
            applyStimulus(32'h1111_2222, 1'b1, 1'b1);
            applyStimulus(32'h1111_2222, 1'b0, 1'b1);
            checkOutput("skew_no_pending", 32'(update_pending), 32'd0);
        end
        applyStimulus(32'h1111_2222, 1'b0, 1'b1);
        checkOutput("skew_pending_3", 32'(update_pending), 32'd0);
        applyStimulus(32'h1111_2222, 1'b0, 1'b1);
        checkOutput("skew_pending_4", 32'(update_pending), 32'd1);
        checkOutput("skew_count_hold", 32'(update_count), 32'd1);
        exp_q.push_back(32'h1111_2222);
        applyStimulus(32'h1111_2222, 1'b1, 1'b1);
        checkOutput("skew_taps", {coef_b18, coef_b19}, 32'h1111_2222);
        checkOutput("skew_count", 32'(update_count), 32'd2);

        // load_en low freezes the pending word
        repeat (4) applyStimulus(32'h0003_0004, 1'b0, 1'b0);
        checkOutput("frz_pending", 32'(update_pending), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h0003_0004, 1'b1, 1'b0);
            applyStimulus(32'h0003_0004, 1'b0, 1'b0);
        end
        checkOutput("frz_count", 32'(update_count), 32'd2);
        checkOutput("frz_taps", {coef_b18, coef_b19}, 32'h1111_2222);
        checkOutput("frz_still_pending", 32'(update_pending), 32'd1);
        exp_q.push_back(32'h0003_0004);
        applyStimulus(32'h0003_0004, 1'b1, 1'b1);
        checkOutput("frz_commit_count", 32'(update_count), 32'd3);
        checkOutput("frz_commit_taps", {coef_b18, coef_b19}, 32'h0003_0004);

        // Commit wins over a simultaneous word change
        repeat (4) applyStimulus(32'h0007_0008, 1'b0, 1'b1);
        checkOutput("race_pending", 32'(update_pending), 32'd1);
        exp_q.push_back(32'h0007_0008);
        exp_q.push_back(32'h0005_0006);
        applyStimulus(32'h0005_0006, 1'b1, 1'b1);
        checkOutput("race_old_taps", {coef_b18, coef_b19}, 32'h0007_0008);
        checkOutput("race_count1", 32'(update_count), 32'd4);
        repeat (3) applyStimulus(32'h0005_0006, 1'b0, 1'b1);
        checkOutput("race_requal_early", 32'(update_pending), 32'd0);
        applyStimulus(32'h0005_0006, 1'b0, 1'b1);
        checkOutput("race_requal", 32'(update_pending), 32'd1);
        applyStimulus(32'h0005_0006, 1'b1, 1'b1);
        checkOutput("race_new_taps", {coef_b18, coef_b19}, 32'h0005_0006);
        checkOutput("race_count2", 32'(update_count), 32'd5);

        // Most-negative halves, one commit only
        repeat (4) applyStimulus(32'h8000_8000, 1'b0, 1'b1);
        exp_q.push_back(exp_clamp);
        applyStimulus(32'h8000_8000, 1'b1, 1'b1);
        checkOutput("clamp_taps", {coef_b18, coef_b19}, exp_clamp);
        for (int i = 0; i < 6; i++) applyStimulus(32'h8000_8000, 1'b1, 1'b1);
        checkOutput("clamp_no_retrigger", 32'(update_count), 32'd6);
        checkOutput("clamp_no_pending", 32'(update_pending), 32'd0);

        // Asynchronous reset mid-qualification discards the staged word
        repeat (4) applyStimulus(32'h1234_5678, 1'b0, 1'b1);
        checkOutput("midrst_pending_pre", 32'(update_pending), 32'd1);
        #2;
        user_rst_n = 1'b0;
        #1;
        checkOutput("midrst_pending", 32'(update_pending), 32'd0);
        checkOutput("midrst_taps", {coef_b18, coef_b19}, 32'h0);
        checkOutput("midrst_count", 32'(update_count), 32'd0);
        user_data_in = 32'h0;
        @(negedge user_clk);
        user_rst_n = 1'b1;
        repeat (6) applyStimulus(32'h0, 1'b1, 1'b1);
        checkOutput("post_rst_count", 32'(update_count), 32'd0);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
